phase_controller: RTL
=====================

Name: phase_controller

Overview:
- Multi-cycle sequencer for the 16-bit processor core; drives the five instruction phases: P1 fetch, P2 decode/register read, P3 ALU execute, P4 memory, P5 writeback.
- Produces one-hot phase strobes and write enables for the program counter, instruction register, register file and flag register.
- Holds the architectural SZCV flag register, loaded from the ALU's szcv output.
- Evaluates conditional-branch decisions from the latched flags.
- Stalls P4 on slow memory and stops on HLT.

Parameters:
- MEM_TIMEOUT, 15: maximum P4 wait cycles before the fault state is entered; 4-bit counter, legal range 1..15.
- RESET_FLAGS, 4'b0000: SZCV value loaded on reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; leaves IDLE
- ir_op1  in  2  instruction format field, valid from P2
- ir_op3  in  4  operation field, valid from P2
- ir_cond  in  3  branch condition field, valid from P2
- is_branch  in  1  decoded conditional branch, valid from P2
- halt_req  in  1  decoded HLT, sampled in P2
- mem_req  in  1  current instruction accesses memory in P4
- mem_ready  in  1  memory handshake complete
- alu_szcv  in  4  ALU flags, valid in P3
- phase  out  5  one-hot {P5,P4,P3,P2,P1}
- ir_we  out  1  instruction register load
- pc_we  out  1  program counter update
- reg_we  out  1  register file write
- flag_we  out  1  flag register load (observability)
- szcv  out  4  latched flags
- branch_taken  out  1  branch condition true
- running  out  1  state is P1..P5
- halted  out  1  HLT reached
- fault  out  1  memory timeout occurred

Behaviour:
- States: IDLE, P1, P2, P3, P4, P5, HALT, FAULT. On reset: IDLE; phase=0; all enables 0; szcv=RESET_FLAGS; halted=0; fault=0; timer=0. Reset wins over every other input in the same cycle, including mid-phase and in HALT/FAULT.
- IDLE -> P1 on start; otherwise stay.
- P1 -> P2: ir_we=1 and pc_we=1 during P1 (PC+1).
- P2 -> HALT if halt_req; otherwise P2 -> P3.
- P3 -> P4. flag_we=1 in P3 when ir_op1==2'b11 and ir_op3 is in {0000..0110, 1000..1011}; szcv<=alu_szcv at the end of P3. No other op3 and no other op1 changes szcv.
- P4, mem_req=0: P4 -> P5 after one cycle.
- P4, mem_req=1: stay in P4 while mem_ready=0, timer increments. Leave for P5 in the cycle mem_ready=1. When the timer reaches MEM_TIMEOUT with mem_ready still 0: enter FAULT. mem_ready and the timeout in the same cycle: mem_ready wins. Timer clears on leaving P4.
- P5 -> P1: reg_we=1 if (ir_op1==2'b11 and ir_op3 not CMP 0101, and ir_op3 <= 1011) or ir_op1==2'b00 (load).
- branch_taken (combinational, meaningful in P5; pc_we=1 in P5 when is_branch and branch_taken), with S,Z,V taken from szcv:
  - cond 000: Z
  - cond 001: S^V
  - cond 010: Z|(S^V)
  - cond 011: ~Z
  - cond others: 0
- Flags produced in P3 of instruction N are used by a branch in instruction N+1; no forwarding is needed because of the sequential phases.
- HALT and FAULT are sticky until reset; halted=1 in HALT, fault=1 in FAULT; phase=0; start is ignored in both.
- running=1 in P1..P5.
- phase is registered, one-hot and matches the state; enables are combinational from the state.

Optional Feature:
- Macro PHASE_CTRL_STEP_EN adds a step input port (1 bit) and a PAUSE state.
- With the macro: P5 -> PAUSE instead of P1; PAUSE -> P1 on a step pulse; running=0 in PAUSE.
- Without the macro: the port and state are absent and P5 -> P1 directly.

Decomposition:
- Shared package holds: the state enum; the op3 encodings (ADD..SRA, CMP=4'b0101); the op1 format codes; the condition codes; the phase bit indices.
- One sub-module, branch_cond_eval: combinational, inputs szcv and cond, output taken; reused by the decoder for diagnostics.

Test Plan:
- Straight-line run: reset, start, non-memory ADD (op1=11, op3=0000), mem_req=0 -> phase goes 00001, 00010, 00100, 01000, 10000 then back to 00001; ir_we in P1 only; reg_we in P5.
- Flag latch: alu_szcv=4'b0100 in P3 with op1=11, op3=0101 -> szcv=0100 from the next cycle, reg_we=0 in P5. Next instruction is a branch with cond=000 -> branch_taken=1 and pc_we=1 in P5.
- Memory stall: mem_req=1 with mem_ready low for 3 cycles -> phase holds P4 for 4 cycles total, then P5.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=15 -> FAULT and fault=1; a following start is ignored; reset returns to IDLE.
- HLT: halt_req=1 in P2 -> halted=1 and phase=0 from the next cycle. Reset asserted during P3 in a separate run -> IDLE next cycle, szcv=RESET_FLAGS.
- PHASE_CTRL_STEP_EN: after P5 the state holds in PAUSE for 10 cycles without step; a step pulse -> P1 the next cycle.

Source files
------------

// File: rtl/phase_controller_pkg.sv
// ---------------------------------------------------------------------------
// phase_controller_pkg
// Shared definitions for the five-phase instruction sequencer of the 16-bit
// core: the sequencer state enum, instruction field encodings, branch
// condition codes, phase strobe bit positions and decode helpers.
//
// Optional build macro: PHASE_CTRL_STEP_EN adds the PAUSE state used for
// single-stepping.
// ---------------------------------------------------------------------------
package phase_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_P4,
        ST_P5,
        ST_HALT,
        ST_FAULT
`ifdef PHASE_CTRL_STEP_EN
        , ST_PAUSE
`endif
    } state_t;

    // Instruction format field (op1)
    localparam logic [1:0] OP1_LOAD   = 2'b00;
    localparam logic [1:0] OP1_STORE  = 2'b01;
    localparam logic [1:0] OP1_BRANCH = 2'b10;
    localparam logic [1:0] OP1_ALU    = 2'b11;

    // ALU operation field (op3); 0111 is unassigned, 1100..1111 are non-ALU
    localparam logic [3:0] OP3_ADD  = 4'b0000;
    localparam logic [3:0] OP3_SUB  = 4'b0001;
    localparam logic [3:0] OP3_AND  = 4'b0010;
    localparam logic [3:0] OP3_OR   = 4'b0011;
    localparam logic [3:0] OP3_XOR  = 4'b0100;
    localparam logic [3:0] OP3_CMP  = 4'b0101;
    localparam logic [3:0] OP3_MOV  = 4'b0110;
    localparam logic [3:0] OP3_RSV7 = 4'b0111;
    localparam logic [3:0] OP3_SLL  = 4'b1000;
    localparam logic [3:0] OP3_SLR  = 4'b1001;
    localparam logic [3:0] OP3_SRL  = 4'b1010;
    localparam logic [3:0] OP3_SRA  = 4'b1011;

    // Branch condition field
    localparam logic [2:0] COND_EQ = 3'b000;  // Z
    localparam logic [2:0] COND_LT = 3'b001;  // S^V
    localparam logic [2:0] COND_LE = 3'b010;  // Z|(S^V)
    localparam logic [2:0] COND_NE = 3'b011;  // ~Z

    // Bit positions inside the one-hot phase vector {P5,P4,P3,P2,P1}
    localparam int PH_P1 = 0;
    localparam int PH_P2 = 1;
    localparam int PH_P3 = 2;
    localparam int PH_P4 = 3;
    localparam int PH_P5 = 4;

    // Registered status outputs, all derived from the state being entered
    typedef struct packed {
        logic [4:0] phase;
        logic       running;
        logic       halted;
        logic       fault;
    } status_t;

    function automatic status_t status_of(state_t s);
        status_t st;
        // NOTE: every field gets a default first so no decode path leaves one unassigned.
        st = '0;
        case (s)
            ST_P1:    begin st.phase[PH_P1] = 1'b1; st.running = 1'b1; end
            ST_P2:    begin st.phase[PH_P2] = 1'b1; st.running = 1'b1; end
            ST_P3:    begin st.phase[PH_P3] = 1'b1; st.running = 1'b1; end
            ST_P4:    begin st.phase[PH_P4] = 1'b1; st.running = 1'b1; end
            ST_P5:    begin st.phase[PH_P5] = 1'b1; st.running = 1'b1; end
            ST_HALT:  st.halted = 1'b1;
            ST_FAULT: st.fault  = 1'b1;
            default:  st = '0;
        endcase
        return st;
    endfunction

    // ALU ops that update SZCV: ADD..MOV and SLL..SRA (0111 excluded)
    function automatic logic is_flag_op(logic [1:0] op1, logic [3:0] op3);
        return (op1 == OP1_ALU) && (op3 != OP3_RSV7) && (op3 <= OP3_SRA);
    endfunction

    // Register write-back: every ALU op except CMP, plus loads
    function automatic logic is_reg_write_op(logic [1:0] op1, logic [3:0] op3);
        return ((op1 == OP1_ALU) && (op3 != OP3_CMP) && (op3 <= OP3_SRA))
               || (op1 == OP1_LOAD);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch-condition evaluator; also reused by the decoder for
// diagnostics.
//
// Ports:
//   szcv  in  4  flags {S,Z,C,V}
//   cond  in  3  condition code
//   taken out 1  condition true (unknown codes evaluate false)
// ---------------------------------------------------------------------------
module branch_cond_eval
    import phase_controller_pkg::*;
(
    input  logic [3:0] szcv,
    input  logic [2:0] cond,
    output logic       taken
);

    logic s;
    logic z;
    logic v;
    logic unused_carry;  // no supported condition looks at C

    assign s            = szcv[3];
    assign z            = szcv[2];
    assign unused_carry = szcv[1];
    assign v            = szcv[0];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_LT: taken = s ^ v;
            COND_LE: taken = z | (s ^ v);
            COND_NE: taken = ~z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_controller.sv
// ---------------------------------------------------------------------------
// phase_controller
// Multi-cycle sequencer for the 16-bit core. Steps each instruction through
// P1 fetch, P2 decode, P3 execute, P4 memory, P5 writeback; owns the SZCV
// flag register and resolves conditional branches from it.
//
// Optional build macro: PHASE_CTRL_STEP_EN adds the 'step' input and a PAUSE
// state entered after every P5; a step pulse resumes at P1.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   start             pulse that leaves IDLE
//   ir_op1/op3/cond   instruction fields, valid from P2
//   is_branch         conditional branch, valid from P2
//   halt_req          HLT, sampled in P2
//   mem_req/mem_ready memory access request and completion handshake (P4)
//   alu_szcv          ALU flags, valid in P3
//   step              (PHASE_CTRL_STEP_EN only) resume from PAUSE
//   phase             registered one-hot {P5,P4,P3,P2,P1}
//   ir_we, pc_we, reg_we, flag_we   combinational write enables
//   szcv              latched flags
//   branch_taken      condition of ir_cond on szcv
//   running, halted, fault          registered status
// ---------------------------------------------------------------------------
module phase_controller
    import phase_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,       // 1..15 stall cycles
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] ir_op1,
    input  logic [3:0] ir_op3,
    input  logic [2:0] ir_cond,
    input  logic       is_branch,
    input  logic       halt_req,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic [3:0] alu_szcv,
`ifdef PHASE_CTRL_STEP_EN
    input  logic       step,
`endif
    output logic [4:0] phase,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       flag_we,
    output logic [3:0] szcv,
    output logic       branch_taken,
    output logic       running,
    output logic       halted,
    output logic       fault
);

    localparam logic [3:0] TIMEOUT_LIMIT = 4'(MEM_TIMEOUT);

    state_t     state;
    status_t    status;
    logic [3:0] timer;

    branch_cond_eval u_cond (
        .szcv  (szcv),
        .cond  (ir_cond),
        .taken (branch_taken)
    );

    assign phase   = status.phase;
    assign running = status.running;
    assign halted  = status.halted;
    assign fault   = status.fault;

    assign ir_we   = (state == ST_P1);
    assign flag_we = (state == ST_P3) && is_flag_op(ir_op1, ir_op3);
    assign reg_we  = (state == ST_P5) && is_reg_write_op(ir_op1, ir_op3);
    assign pc_we   = (state == ST_P1)
                     || ((state == ST_P5) && is_branch && branch_taken);

    // Status is loaded with the decode of the state being entered, so phase
    // and the flags always match the current state without a decode delay.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every branch sees pre-edge state.
        if (reset) begin
            state  <= ST_IDLE;
            status <= '0;
            timer  <= '0;
            szcv   <= RESET_FLAGS;
        end else begin
            if (flag_we) begin
                szcv <= alu_szcv;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_P1;
                        status <= status_of(ST_P1);
                    end
                end
                ST_P1: begin
                    state  <= ST_P2;
                    status <= status_of(ST_P2);
                end
                ST_P2: begin
                    if (halt_req) begin
                        state  <= ST_HALT;
                        status <= status_of(ST_HALT);
                    end else begin
                        state  <= ST_P3;
                        status <= status_of(ST_P3);
                    end
                end
                ST_P3: begin
                    state  <= ST_P4;
                    status <= status_of(ST_P4);
                end
                ST_P4: begin
                    // mem_ready is checked first so it wins over a timeout
                    // expiring in the same cycle.
                    if (!mem_req || mem_ready) begin
                        state  <= ST_P5;
                        status <= status_of(ST_P5);
                        timer  <= '0;
                    end else if (timer == TIMEOUT_LIMIT) begin
                        state  <= ST_FAULT;
                        status <= status_of(ST_FAULT);
                        timer  <= '0;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                ST_P5: begin
`ifdef PHASE_CTRL_STEP_EN
                    state  <= ST_PAUSE;
                    status <= status_of(ST_PAUSE);
`else
                    state  <= ST_P1;
                    status <= status_of(ST_P1);
`endif
                end
`ifdef PHASE_CTRL_STEP_EN
                ST_PAUSE: begin
                    if (step) begin
                        state  <= ST_P1;
                        status <= status_of(ST_P1);
                    end
                end
`endif
                ST_HALT, ST_FAULT: begin
                    // Sticky until reset; start is ignored.
                end
                default: begin
                    state  <= ST_IDLE;
                    status <= '0;
                    timer  <= '0;
                end
            endcase
        end
    end

endmodule
